// File: rtl/rom_download_bridge.sv
// rom_download_bridge
//
// Bridges the data_io download stream (ioctl_*) onto an SDRAM write port that
// uses a toggle req/ack handshake. Consecutive even/odd bytes of one word are
// packed into a single 16-bit write. Each download is relocated by a per-region
// word base chosen from ioctl_index. Writes are queued in a small FIFO so the
// SDRAM may fall behind the byte stream.
//
// Optional feature: define ROM_CHECKSUM_EN to add a 16-bit wrapping sum of every
// byte that made it into the FIFO (exposed on the checksum port).
//
// Parameters
//   AW          SDRAM word-address width (at most 24)
//   FIFO_DEPTH  write FIFO entries, power of 2, at least 2
//   REGIONS     number of relocation regions, power of 2
//   REGION_BASE packed word bases, region r at bits [r*AW +: AW]
//
// Ports
//   clk_sys         system clock
//   reset           synchronous, active-high
//   ioctl_download  download in progress
//   ioctl_index     region select (low log2(REGIONS) bits)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address within the download
//   ioctl_dout      byte data
//   port_req        toggles once per issued write
//   port_ack        equals port_req once the SDRAM has finished the write
//   port_a          word address
//   port_ds         byte enables {hi,lo}
//   port_we         high while a write is outstanding
//   port_d          write data
//   busy            download active or any work still pending
//   done            one-cycle pulse when busy falls
//   overflow        sticky, a byte was dropped because the FIFO was full
//   checksum        (ROM_CHECKSUM_EN only) sum of accepted bytes

module rom_download_bridge #(
    parameter int                     AW          = 22,
    parameter int                     FIFO_DEPTH  = 8,
    parameter int                     REGIONS     = 4,
    parameter logic [REGIONS*AW-1:0]  REGION_BASE = '0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-1:0] port_a,
    output logic [1:0]    port_ds,
    output logic          port_we,
    output logic [15:0]   port_d,
    output logic          busy,
    output logic          done,
    output logic          overflow
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]   checksum
`endif
);

    localparam int RW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state;
    logic            dl_q;
    logic            held_valid;
    logic [AW-1:0]   held_addr;
    logic [7:0]      held_data;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [AW-1:0]   region_base;
    logic [AW-1:0]   word_addr;
    logic            strobe;
    logic            dl_rise;
    logic            dl_fall;
    logic            pair;
    logic            flush;
    logic            lone_odd;
    logic            new_hold;
    logic            push0_valid;
    logic            push1_valid;
    logic [EW-1:0]   push0_entry;
    logic [EW-1:0]   push1_entry;
    logic            pop;
    logic [CW-1:0]   room;
    logic            accept0;
    logic            accept1;
    logic            drop;
    logic            busy_now;
    logic            unused_bits;

    // Only the low index bits and the word part of the byte address matter.
    assign unused_bits = ^{ioctl_index, ioctl_addr};

    // Pick the relocation base for the region currently being downloaded.
    always_comb begin
        region_base = '0;
        for (int r = 0; r < REGIONS; r++) begin
            if (REGIONS == 1 || ioctl_index[RW-1:0] == RW'(r)) begin
                region_base = REGION_BASE[r*AW +: AW];
            end
        end
    end

    assign word_addr = region_base + ioctl_addr[AW:1];

    assign strobe   = ioctl_wr & ioctl_download;
    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = dl_q & ~ioctl_download;
    assign pair     = strobe & held_valid & ioctl_addr[0] & (word_addr == held_addr);
    assign flush    = held_valid & ((strobe & ~pair) | dl_fall);
    assign lone_odd = strobe & ioctl_addr[0] & ~pair;
    assign new_hold = strobe & ~ioctl_addr[0];

    // Up to two FIFO pushes per cycle: a flushed held byte always occupies
    // the first slot so ordering is kept, a lone odd byte may follow it.
    always_comb begin
        push0_valid = 1'b0;
        push1_valid = 1'b0;
        push0_entry = '0;
        push1_entry = '0;
        if (pair) begin
            push0_valid = 1'b1;
            push0_entry = {held_addr, ioctl_dout, held_data, 2'b11};
        end else if (flush) begin
            push0_valid = 1'b1;
            push0_entry = {held_addr, held_data, held_data, 2'b01};
            if (lone_odd) begin
                push1_valid = 1'b1;
                push1_entry = {word_addr, ioctl_dout, ioctl_dout, 2'b10};
            end
        end else if (lone_odd) begin
            push0_valid = 1'b1;
            push0_entry = {word_addr, ioctl_dout, ioctl_dout, 2'b10};
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop     = (state == S_ISSUE);
    assign room    = CW'(FIFO_DEPTH) - count + CW'(pop);
    assign accept0 = push0_valid & (room != '0);
    assign accept1 = push1_valid & (room > CW'(1));
    assign drop    = (push0_valid & ~accept0) | (push1_valid & ~accept1);

    assign busy_now = ioctl_download | held_valid | (count != '0) | (state != S_IDLE);

    // Track the download level and the pending even byte.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            held_valid <= 1'b0;
            held_addr  <= '0;
            held_data  <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (new_hold) begin
                held_valid <= 1'b1;
                held_addr  <= word_addr;
                held_data  <= ioctl_dout;
            end else if (pair || flush) begin
                held_valid <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (accept0) begin
            fifo_mem[wr_ptr] <= push0_entry;
        end
        if (accept1) begin
            fifo_mem[wr_ptr + PW'(1)] <= push1_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(accept0) + PW'(accept1);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(accept0) + CW'(accept1) - CW'(pop);
        end
    end

    // Issue FSM: one write in flight at a time. Reset re-aligns req with ack,
    // which abandons any write the SDRAM has not acknowledged yet.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_IDLE;
            port_req <= port_ack;
            port_we  <= 1'b0;
            port_a   <= '0;
            port_d   <= '0;
            port_ds  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    {port_a, port_d, port_ds} <= fifo_mem[rd_ptr];
                    port_req <= ~port_req;
                    port_we  <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (port_ack == port_req) begin
                        port_we <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags. done fires on the same edge that drops busy.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= busy_now;
            done <= busy & ~busy_now;
            if (drop) begin
                overflow <= 1'b1;
            end else if (dl_rise) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum0;
    logic [15:0] sum1;

    // Bytes count only once they are safely in the FIFO.
    always_comb begin
        sum1 = {8'h00, ioctl_dout};
        if (pair) begin
            sum0 = {8'h00, held_data} + {8'h00, ioctl_dout};
        end else if (flush) begin
            sum0 = {8'h00, held_data};
        end else begin
            sum0 = {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            checksum <= '0;
        end else begin
            checksum <= (dl_rise ? 16'h0000 : checksum)
                      + (accept0 ? sum0 : 16'h0000)
                      + (accept1 ? sum1 : 16'h0000);
        end
    end
`endif

endmodule
